instr_encoder: RTL and testbench

- Sequential RV32I instruction encoder. It is the inverse of the IF-stage instruction decoder.
- Accepts field-level descriptions of an instruction (kind, funct3, alt bit, rd/rs1/rs2, full 32-bit immediate) on a valid/ready input.
- Range-checks the fields, packs them into a 32-bit instruction word, and buffers the result in a small FIFO for a valid/ready consumer.
- Used by the self-check bench and the debug instruction-injection path that feed the fetch/decode stage.

---
 rtl/rv_enc_pkg.sv | 27 ++
 rtl/enc_fifo.sv | 44 ++++
 rtl/instr_encoder.sv | 129 ++++++++++++
 tb/tb_instr_encoder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/rv_enc_pkg.sv
// Shared constants for the RV32I field-level instruction encoder.
package rv_enc_pkg;

  localparam logic [3:0] KIND_LUI    = 4'd0;
  localparam logic [3:0] KIND_AUIPC  = 4'd1;
  localparam logic [3:0] KIND_JAL    = 4'd2;
  localparam logic [3:0] KIND_JALR   = 4'd3;
  localparam logic [3:0] KIND_BRANCH = 4'd4;
  localparam logic [3:0] KIND_LOAD   = 4'd5;
  localparam logic [3:0] KIND_STORE  = 4'd6;
  localparam logic [3:0] KIND_OP_IMM = 4'd7;
  localparam logic [3:0] KIND_OP     = 4'd8;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRL = 3'b101;

endpackage

// File: rtl/enc_fifo.sv
// Generic synchronous FIFO; head data reads as zero whenever the FIFO is empty.
module enc_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      cnt_q <= cnt_q + 1'b1;
      else if (pop_i && !push_i) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage needs no reset: the empty mux hides stale contents.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder with legality checking, output FIFO and
// saturating pop statistics.
module instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_kind,
  input  logic [2:0]       in_funct3,
  input  logic             in_alt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ir,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  logic [31:0] raw, enc_ir;
  logic        bad, enc_err;
  logic        i_ok, b_ok, j_ok;
  logic        full, empty, push, pop;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d, err_cnt_q, err_cnt_d;

  // Immediate fits when every bit above the format's sign bit matches it.
  assign i_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign b_ok = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign j_ok = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    raw = '0;
    bad = 1'b0;
    case (in_kind)
      KIND_LUI: begin
        raw = {in_imm[31:12], in_rd, OPC_LUI};
        bad = |in_imm[11:0];
      end
      KIND_AUIPC: begin
        raw = {in_imm[31:12], in_rd, OPC_AUIPC};
        bad = |in_imm[11:0];
      end
      KIND_JAL: begin
        raw = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
        bad = !j_ok || in_imm[0];
      end
      KIND_JALR: begin
        raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_JALR};
        bad = !i_ok || (in_funct3 != 3'b000);
      end
      KIND_BRANCH: begin
        raw = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
               in_imm[4:1], in_imm[11], OPC_BRANCH};
        bad = !b_ok || in_imm[0] || (in_funct3 == 3'b010) || (in_funct3 == 3'b011);
      end
      KIND_LOAD: begin
        raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
        bad = !i_ok || (in_funct3 == 3'b011) || (in_funct3 == 3'b110) ||
              (in_funct3 == 3'b111);
      end
      KIND_STORE: begin
        raw = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
        bad = !i_ok || (in_funct3 > 3'b010);
      end
      KIND_OP_IMM: begin
        if (in_funct3 == F3_SLL || in_funct3 == F3_SRL) begin
          raw = {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_OP_IMM};
          bad = (|in_imm[31:5]) || (in_funct3 == F3_SLL && in_alt);
        end else begin
          raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OP_IMM};
          bad = !i_ok;
        end
      end
      KIND_OP: begin
        raw = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
        bad = in_alt && !(in_funct3 == 3'b000 || in_funct3 == F3_SRL);
      end
      default: bad = 1'b1;
    endcase
  end

  assign enc_err = bad;
  assign enc_ir  = bad ? 32'h0 : raw;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;

  enc_fifo #(.WIDTH(33), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i ({enc_err, enc_ir}),
    .pop_i   (pop),
    .rdata_o ({out_err, out_ir}),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (pop && !(&enc_cnt_q))            enc_cnt_d = enc_cnt_q + 1'b1;
    if (pop && out_err && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign enc_count = enc_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, legality, backpressure,
// counter saturation and asynchronous reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_kind = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_alt = 1'b0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_ir;
  logic        out_err;
  logic [3:0]  enc_count, err_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_alt(in_alt),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_fields(input logic [3:0] k, input logic [2:0] f3, input logic alt,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
    in_kind = k; in_funct3 = f3; in_alt = alt;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // Called #1 after an edge; pushes on the next edge.
  task automatic push(input string tag, input logic [3:0] k, input logic [2:0] f3,
                      input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    set_fields(k, f3, alt, rd, rs1, rs2, imm);
    chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] ir, input logic err,
                         input logic [3:0] enc_c, input logic [3:0] err_c);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".ir"},    out_ir, ir);
    chk({tag, ".err"},   {31'b0, out_err}, {31'b0, err});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".enc_count"}, {28'b0, enc_count}, {28'b0, enc_c});
    chk({tag, ".err_count"}, {28'b0, err_count}, {28'b0, err_c});
  endtask

  task automatic one(input string tag, input logic [3:0] k, input logic [2:0] f3,
                     input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm,
                     input logic [31:0] ir, input logic err,
                     input logic [3:0] enc_c, input logic [3:0] err_c);
    push(tag, k, f3, alt, rd, rs1, rs2, imm);
    pop_chk(tag, ir, err, enc_c, err_c);
    chk({tag, ".empty_ir"}, out_ir, 32'h0);
  endtask

  logic [31:0] got [3];
  int npop;
  bit c_taken;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.out_ir",    out_ir, 32'h0);
    chk("rst.out_err",   {31'b0, out_err}, 32'd0);
    chk("rst.enc_count", {28'b0, enc_count}, 32'd0);
    chk("rst.err_count", {28'b0, err_count}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);

    one("addi",      4'd7,  3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,          32'h00500093, 1'b0, 4'd1,  4'd0);
    one("lui",       4'd0,  3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000,   32'h123452B7, 1'b0, 4'd2,  4'd0);
    one("lui_bad",   4'd0,  3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345001,   32'h0,        1'b1, 4'd3,  4'd1);
    one("beq",       4'd4,  3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   32'hFE208EE3, 1'b0, 4'd4,  4'd1);
    one("sub",       4'd8,  3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0,          32'h402081B3, 1'b0, 4'd5,  4'd1);
    one("jal_odd",   4'd2,  3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3,          32'h0,        1'b1, 4'd6,  4'd2);
    one("kind12",    4'd12, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0,          32'h0,        1'b1, 4'd7,  4'd3);
    one("srai",      4'd7,  3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,          32'h40315093, 1'b0, 4'd8,  4'd3);
    one("sw",        4'd6,  3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423, 1'b0, 4'd9,  4'd3);
    one("jal",       4'd2,  3'd0, 1'b0, 5'd1, 5'd7, 5'd7, 32'd8,          32'h008000EF, 1'b0, 4'd10, 4'd3);
    one("addi_min",  4'd7,  3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800,   32'h80000093, 1'b0, 4'd11, 4'd3);
    one("addi_2048", 4'd7,  3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00000800,   32'h0,        1'b1, 4'd12, 4'd4);

    // Backpressure: fill both entries, hold C while full, then drain.
    push("bp.A", 4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    push("bp.B", 4'd7, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2);
    set_fields(4'd7, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd3);
    in_valid = 1'b1;
    chk("bp.full_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("bp.hold_ready", {31'b0, in_ready}, 32'd0);
    chk("bp.hold_head",  out_ir, 32'h00100093);
    out_ready = 1'b1;
    npop = 0;
    c_taken = 1'b0;
    for (int cyc = 0; cyc < 10 && npop < 3; cyc++) begin
      if (in_valid && in_ready) c_taken = 1'b1;
      if (out_valid) begin
        got[npop] = out_ir;
        npop++;
      end
      @(posedge clk); #1;
      if (c_taken) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp.npop",  npop, 32'd3);
    chk("bp.pop0",  got[0], 32'h00100093);
    chk("bp.pop1",  got[1], 32'h00200113);
    chk("bp.pop2",  got[2], 32'h00300193);
    chk("bp.empty", {31'b0, out_valid}, 32'd0);
    chk("bp.enc_count", {28'b0, enc_count}, 32'd15);

    one("sat", 4'd7, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'd4, 32'h00400213, 1'b0, 4'd15, 4'd4);

    // Reset with two entries queued.
    push("rq.A", 4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    push("rq.B", 4'd7, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2);
    chk("rq.full", {31'b0, in_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rq.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rq.enc_count", {28'b0, enc_count}, 32'd0);
    chk("rq.err_count", {28'b0, err_count}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rq.in_ready", {31'b0, in_ready}, 32'd1);
    chk("rq.idle",     {31'b0, out_valid}, 32'd0);
    one("rq.new", 4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd5, 32'h00500293, 1'b0, 4'd1, 4'd0);
    chk("rq.drained", {31'b0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
